// File: rtl/pwm_in_capture.sv
// RC-receiver PWM input: 2-FF sync, glitch filter, high-time/period capture, 4-word Avalon-MM slave.
// Optional level interrupt output and CTRL.ie bit are enabled by defining PWM_CAP_IRQ_EN.
module pwm_in_capture #(
  parameter int CNT_W       = 24,
  parameter int FILT_CYC    = 4,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port
`ifdef PWM_CAP_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  logic             sync_p0, sync_p1;
  logic             filt, filt_prev;
  logic [FW-1:0]    run_cnt;
  logic [CNT_W-1:0] cnt_p, cnt_h, high_r, period_r;
  logic             armed, new_flag, ovr_flag, to_flag;
  logic             en_r, ie_r;
  logic             rise, capture, timeout, rd_status, rd_period, wr_ctrl;

  assign rise      = filt & ~filt_prev;
  assign capture   = en_r & rise & armed;
  assign timeout   = en_r & ~rise & (cnt_p == TO_VAL);
  assign rd_status = read & (address == 2'd0);
  assign rd_period = read & (address == 2'd2);
  assign wr_ctrl   = write & (address == 2'd3);

  // Stage p0/p1: synchroniser, then run-length glitch filter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      filt      <= 1'b0;
      filt_prev <= 1'b0;
      run_cnt   <= '0;
    end else begin
      sync_p0   <= in_port;
      sync_p1   <= sync_p0;
      filt_prev <= filt;
      if (sync_p1 == filt) begin
        run_cnt <= '0;
      end else if (run_cnt == FILT_LAST) begin
        filt    <= sync_p1;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  // Stage p2: measurement counters; a rise restarts both, counting the rise cycle itself
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p <= '0;
      cnt_h <= '0;
      armed <= 1'b0;
    end else if (!en_r) begin
      cnt_p <= '0;
      cnt_h <= '0;
      armed <= 1'b0;
    end else if (rise) begin
      cnt_p <= CNT_ONE;
      cnt_h <= CNT_ONE;
      armed <= 1'b1;
    end else begin
      if (cnt_p != TO_VAL) cnt_p <= sat_inc(cnt_p);
      if (filt) cnt_h <= sat_inc(cnt_h);
      if (timeout) armed <= 1'b0;
    end
  end

  // Results and sticky flags; a capture's set takes priority over a read's clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_r   <= '0;
      period_r <= '0;
      new_flag <= 1'b0;
      ovr_flag <= 1'b0;
      to_flag  <= 1'b1;
    end else begin
      if (capture) begin
        high_r   <= cnt_h;
        period_r <= cnt_p;
        to_flag  <= 1'b0;
      end else if (timeout) begin
        high_r   <= '0;
        period_r <= '0;
        to_flag  <= 1'b1;
      end
      if (capture)        new_flag <= 1'b1;
      else if (rd_period) new_flag <= 1'b0;
      if (capture && new_flag) ovr_flag <= 1'b1;
      else if (rd_status)      ovr_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_r <= 1'b1;
    end else if (wr_ctrl) begin
      en_r <= writedata[0];
    end
  end

`ifdef PWM_CAP_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie_r <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (wr_ctrl) ie_r <= writedata[1];
      irq <= ie_r & (new_flag | to_flag);
    end
  end
  logic unused_wd;
  assign unused_wd = ^writedata[31:2];
`else
  assign ie_r = 1'b0;
  logic unused_wd;
  assign unused_wd = ^writedata[31:1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (read) begin
      case (address)
        2'd0:    readdata <= 32'({filt, to_flag, ovr_flag, new_flag});
        2'd1:    readdata <= 32'(high_r);
        2'd2:    readdata <= 32'(period_r);
        default: readdata <= 32'({ie_r, en_r});
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_in_capture.sv
// Directed bench for pwm_in_capture: register table, filter rejection, capture, overrun, timeout, IRQ.
module tb_pwm_in_capture;

`ifdef PWM_CAP_IRQ_EN
  localparam logic [31:0] CTRL_ALL = 32'h3;
`else
  localparam logic [31:0] CTRL_ALL = 32'h1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        in_port;
`ifdef PWM_CAP_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  pwm_in_capture #(.CNT_W(24), .FILT_CYC(4), .TIMEOUT_CYC(1000)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port)
`ifdef PWM_CAP_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];
  int   n_chk = 0;
  int   n_fail = 0;
  int   t = 0;
  int   t0 = 0;
  int   hi_len = 1;
  int   lo_len = 1;
  logic gen_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive pin for this cycle, pass the rising edge, return at the falling edge.
  task automatic cyc();
    if (gen_on) in_port = (((t - t0) % (hi_len + lo_len)) < hi_len);
    t++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_rel(input int target);
    while ((t - t0) < target) cyc();
  endtask

  task automatic gen_start(input int hi, input int lo);
    hi_len = hi;
    lo_len = lo;
    t0     = t;
    gen_on = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    read    = 1'b1;
    cyc();
    read    = 1'b0;
    check(name, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    cyc();
    write     = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,   32'h4};
    tbl[1]  = '{1'b1, 1'b0, 2'd3, 32'h0,   32'h1};
    tbl[2]  = '{1'b0, 1'b1, 2'd3, 32'h0,   32'h1};
    tbl[3]  = '{1'b1, 1'b0, 2'd3, 32'h0,   32'h0};
    tbl[4]  = '{1'b1, 1'b1, 2'd3, 32'h1,   32'h0};
    tbl[5]  = '{1'b1, 1'b0, 2'd3, 32'h0,   32'h1};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 32'hF,   32'h1};
    tbl[7]  = '{1'b0, 1'b1, 2'd1, 32'h123, 32'h1};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 32'h456, 32'h1};
    tbl[9]  = '{1'b1, 1'b0, 2'd1, 32'h0,   32'h0};
    tbl[10] = '{1'b1, 1'b0, 2'd2, 32'h0,   32'h0};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 32'h0,   32'h4};
    tbl[12] = '{1'b0, 1'b1, 2'd3, 32'h3,   32'h4};
    tbl[13] = '{1'b1, 1'b0, 2'd3, 32'h0,   CTRL_ALL};
    tbl[14] = '{1'b0, 1'b1, 2'd3, 32'h1,   CTRL_ALL};
    tbl[15] = '{1'b1, 1'b0, 2'd3, 32'h0,   32'h1};

    reset_n = 1'b0; address = 2'd0; read = 1'b0; write = 1'b0;
    writedata = 32'h0; in_port = 1'b0;
    cyc(); cyc();
    check("reset_readdata", readdata, 32'h0);
`ifdef PWM_CAP_IRQ_EN
    check("reset_irq", {31'b0, irq}, 32'h0);
`endif
    reset_n = 1'b1;
    cyc();

    // Register map, write-ignore, read/write collision, readdata hold
    for (int i = 0; i < 16; i++) begin
      address = tbl[i].addr; read = tbl[i].rd; write = tbl[i].wr; writedata = tbl[i].wd;
      cyc();
      read = 1'b0; write = 1'b0;
      check($sformatf("tbl%0d", i), readdata, tbl[i].exp);
`ifdef PWM_CAP_IRQ_EN
      if (i == 13) check("irq_ie_to", {31'b0, irq}, 32'h1);
      if (i == 15) check("irq_ie_off", {31'b0, irq}, 32'h0);
`endif
    end

    // Short glitches never reach the filtered level
    gen_start(3, 497);
    run_rel(3);
    rd_chk("glitch_r4", 2'd0, 32'h4);
    rd_chk("glitch_r5", 2'd0, 32'h4);
    rd_chk("glitch_r6", 2'd0, 32'h4);
    rd_chk("glitch_r7", 2'd0, 32'h4);
    run_rel(1100);
    rd_chk("glitch_status", 2'd0, 32'h4);
    rd_chk("glitch_period", 2'd2, 32'h0);
    gen_on = 1'b0; in_port = 1'b0;

    // 150/350 waveform: first rise arms, second captures
    gen_start(150, 350);
    run_rel(300);
    rd_chk("armed_period", 2'd2, 32'h0);
    rd_chk("armed_status", 2'd0, 32'h4);
    run_rel(520);
    rd_chk("cap_high", 2'd1, 32'd150);
    rd_chk("cap_status", 2'd0, 32'h9);
    rd_chk("cap_period", 2'd2, 32'd500);
    rd_chk("cap_new_clr", 2'd0, 32'h8);

    // Three unread captures -> overrun
    run_rel(2200);
    rd_chk("ovr_status", 2'd0, 32'h3);
    rd_chk("ovr_clr", 2'd0, 32'h1);
    rd_chk("ovr_high", 2'd1, 32'd150);
    rd_chk("ovr_period", 2'd2, 32'd500);

    // Pin stuck low: timeout lands on the 1000th cycle after the last rise
    gen_on = 1'b0; in_port = 1'b0;
    run_rel(3005);
    rd_chk("to_before", 2'd0, 32'h0);
    rd_chk("to_edge", 2'd0, 32'h0);
    rd_chk("to_status", 2'd0, 32'h4);
    rd_chk("to_high", 2'd1, 32'h0);
    rd_chk("to_period", 2'd2, 32'h0);
    gen_start(150, 350);
    run_rel(300);
    rd_chk("rearm_period", 2'd2, 32'h0);
    rd_chk("rearm_status", 2'd0, 32'h4);
    run_rel(520);
    rd_chk("recap_status", 2'd0, 32'h9);
    rd_chk("recap_high", 2'd1, 32'd150);
    rd_chk("recap_period", 2'd2, 32'd500);

    // Disable/enable re-arms; read of PERIOD in the capture cycle
    gen_on = 1'b0; in_port = 1'b0;
    wr(2'd3, 32'h0);
    for (int i = 0; i < 10; i++) cyc();
    wr(2'd3, 32'h3);
    rd_chk("ctrl_ie", 2'd3, CTRL_ALL);
`ifdef PWM_CAP_IRQ_EN
    check("irq_idle", {31'b0, irq}, 32'h0);
`endif
    gen_start(100, 300);
    run_rel(406);
    rd_chk("race_old_period", 2'd2, 32'd500);
`ifdef PWM_CAP_IRQ_EN
    check("irq_cap_cycle", {31'b0, irq}, 32'h0);
`endif
    rd_chk("race_new_kept", 2'd0, 32'h9);
`ifdef PWM_CAP_IRQ_EN
    check("irq_set", {31'b0, irq}, 32'h1);
`endif
    rd_chk("race_new_period", 2'd2, 32'd400);
`ifdef PWM_CAP_IRQ_EN
    check("irq_hold", {31'b0, irq}, 32'h1);
`endif
    rd_chk("race_high", 2'd1, 32'd100);
`ifdef PWM_CAP_IRQ_EN
    check("irq_clr", {31'b0, irq}, 32'h0);
`endif

    // Reset in the middle of a high pulse discards everything
    gen_on = 1'b0; in_port = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_readdata", readdata, 32'h0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    rd_chk("midreset_status", 2'd0, 32'h4);
    rd_chk("midreset_high", 2'd1, 32'h0);
    rd_chk("midreset_period", 2'd2, 32'h0);
    rd_chk("midreset_ctrl", 2'd3, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
